// File: rtl/key_debounce.sv
// Debounces active-low push-buttons into clean active-high levels plus one-cycle press/release strobes.
// Optional KEY_DEBOUNCE_TOGGLE_EN adds a per-channel toggle output flipped by each press.
module key_debounce #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key,
  output logic [WIDTH-1:0] held,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] released
`ifdef KEY_DEBOUNCE_TOGGLE_EN
  ,
  output logic [WIDTH-1:0] toggled
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] s;
  logic [CNT_W-1:0] cnt [WIDTH];

  // Synchroniser resets to the released (high) level so reset never looks like a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  // A new level must persist for DEBOUNCE_CYCLES consecutive cycles; any return to held restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held     <= '0;
      pressed  <= '0;
      released <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      pressed  <= '0;
      released <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == held[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          held[i]     <= s[i];
          cnt[i]      <= '0;
          pressed[i]  <= s[i];
          released[i] <= ~s[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef KEY_DEBOUNCE_TOGGLE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) toggled <= '0;
    else        toggled <= toggled ^ pressed;
  end
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4: vector table plus reset and toggle sequences.
// Toggle checks are compiled only when KEY_DEBOUNCE_TOGGLE_EN is defined.
module tb_key_debounce;
  localparam int W  = 2;
  localparam int DC = 4;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] key   = 2'b11;
  logic [W-1:0] held, pressed, released;
`ifdef KEY_DEBOUNCE_TOGGLE_EN
  logic [W-1:0] toggled;
`endif

  key_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .key      (key),
    .held     (held),
    .pressed  (pressed),
    .released (released)
`ifdef KEY_DEBOUNCE_TOGGLE_EN
    ,
    .toggled  (toggled)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] key;
    logic [W-1:0] held;
    logic [W-1:0] pressed;
    logic [W-1:0] released;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  task automatic set_vec(input int j, input logic [W-1:0] k, input logic [W-1:0] h,
                         input logic [W-1:0] p, input logic [W-1:0] r);
    vecs[j].key      = k;
    vecs[j].held     = h;
    vecs[j].pressed  = p;
    vecs[j].released = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int pulses;
    int rel_seen;

    // key[0] bounces 0,0,1,1,0,0,1,1 then settles low; key[1] pressed later; both released together.
    for (int j = 0; j < 2; j++)   set_vec(j, 2'b10, 2'b00, 2'b00, 2'b00);
    for (int j = 2; j < 4; j++)   set_vec(j, 2'b11, 2'b00, 2'b00, 2'b00);
    for (int j = 4; j < 6; j++)   set_vec(j, 2'b10, 2'b00, 2'b00, 2'b00);
    for (int j = 6; j < 8; j++)   set_vec(j, 2'b11, 2'b00, 2'b00, 2'b00);
    for (int j = 8; j < 13; j++)  set_vec(j, 2'b10, 2'b00, 2'b00, 2'b00);
    set_vec(13, 2'b10, 2'b01, 2'b01, 2'b00);
    set_vec(14, 2'b10, 2'b01, 2'b00, 2'b00);
    for (int j = 15; j < 20; j++) set_vec(j, 2'b00, 2'b01, 2'b00, 2'b00);
    set_vec(20, 2'b00, 2'b11, 2'b10, 2'b00);
    set_vec(21, 2'b00, 2'b11, 2'b00, 2'b00);
    for (int j = 22; j < 27; j++) set_vec(j, 2'b11, 2'b11, 2'b00, 2'b00);
    set_vec(27, 2'b11, 2'b00, 2'b00, 2'b11);
    set_vec(28, 2'b11, 2'b00, 2'b00, 2'b00);

    // Reset asserted with keys released: all outputs stay low.
    #2;
    chk("rst_held_async", held, 2'b00);
    chk("rst_pressed_async", pressed, 2'b00);
    chk("rst_released_async", released, 2'b00);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_held", held, 2'b00);
      chk("rst_pulses", pressed | released, 2'b00);
    end
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_held", held, 2'b00);
      chk("post_rst_pulses", pressed | released, 2'b00);
    end

    for (int j = 0; j < NV; j++) begin
      key = vecs[j].key;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_held", j), held, vecs[j].held);
      chk($sformatf("vec%0d_pressed", j), pressed, vecs[j].pressed);
      chk($sformatf("vec%0d_released", j), released, vecs[j].released);
      chk($sformatf("vec%0d_exclusive", j), pressed & released, 2'b00);
    end

    // Reset pulsed while key[0] is held: held drops asynchronously, no release strobe.
    key = 2'b10;
    repeat (8) @(posedge clk);
    #1;
    chk("hold_before_rst", held, 2'b01);
    #2;
    reset = 1'b0;
    #1;
    chk("midhold_rst_held_async", held, 2'b00);
    chk("midhold_rst_released", released, 2'b00);
    repeat (3) begin
      @(posedge clk); #1;
      chk("midhold_rst_held", held, 2'b00);
      chk("midhold_rst_released_cyc", released, 2'b00);
    end
    reset = 1'b1;
    first    = 0;
    pulses   = 0;
    rel_seen = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (pressed[0]) begin
        pulses++;
        if (first == 0) first = n;
      end
      if (released != 2'b00) rel_seen++;
    end
    checks++;
    if (first < DC + 1 || first > DC + 3) begin
      errors++;
      $display("FAIL repress_latency actual=%0d expected=%0d..%0d", first, DC + 1, DC + 3);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL repress_pulse_count actual=%0d expected=1", pulses);
    end
    checks++;
    if (rel_seen != 0) begin
      errors++;
      $display("FAIL repress_no_release actual=%0d expected=0", rel_seen);
    end
    chk("repress_held", held, 2'b01);

`ifdef KEY_DEBOUNCE_TOGGLE_EN
    key = 2'b11;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    chk("tog_rst", toggled, 2'b00);
    reset = 1'b1;
    for (int p = 0; p < 3; p++) begin
      key = 2'b01;
      repeat (9) @(posedge clk);
      #1;
      chk($sformatf("tog_press%0d", p), toggled, (p % 2 == 0) ? 2'b10 : 2'b00);
      key = 2'b11;
      repeat (9) @(posedge clk);
      #1;
      chk($sformatf("tog_release%0d", p), toggled, (p % 2 == 0) ? 2'b10 : 2'b00);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Conditions raw, active-low DE10-Lite push-buttons (`key[1:0]`) before they feed the lab logic in `top`.
- Per channel, the pipeline is: 2-flop synchroniser → polarity inversion → stability counter → clean level output plus one-cycle press and release pulses.
- Sits between the board pins and the lab logic, so the lab logic sees clean active-high `a`/`b` and edge strobes instead of `~key[n]` directly.

Parameters:
- WIDTH, 2: number of independent key channels.
- DEBOUNCE_CYCLES, 500000: consecutive clk cycles the synchronised input must hold a new level before it is accepted (10 ms at 50 MHz). Legal range ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES): counter width, derived. Not overridden.

Ports:
- clk  input  1  system clock (max10_clk1_50).
- reset  input  1  asynchronous, active-low reset.
- key  input  WIDTH  raw buttons, active-low (0 = pressed), asynchronous to clk.
- held  output  WIDTH  debounced level, active-high (1 = pressed).
- pressed  output  WIDTH  one-cycle pulse on an accepted press.
- released  output  WIDTH  one-cycle pulse on an accepted release.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset asserted (reset=0):
  - All state clears immediately, independent of clk.
  - Synchroniser flops = 1 (released). Counters = 0.
  - held = 0, pressed = 0, released = 0.
- Reset deassertion: no pulse is generated. A key held through reset is accepted only after the full debounce interval, then emits `pressed`.
- Synchroniser: two flops per channel on key. `s[i] = ~sync2[i]`, active-high internal level.
- Per-channel state is the counter `cnt[i]` plus the `held[i]` register.
  - If `s[i] == held[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `held[i] <= s[i]`, `cnt[i] <= 0`, and assert `pressed[i]` (if s=1) or `released[i]` (if s=0) in the same cycle `held[i]` changes.
  - Else: `cnt[i] <= cnt[i] + 1`.
- Any glitch back to the held level restarts the count from 0. Partial counts are never kept.
- Latency: a clean key edge at cycle t is visible on held and pulse at cycle t + 2 + DEBOUNCE_CYCLES, within ±1 cycle of sampling alignment.
- `pressed`, `released` and `held` are registered outputs; there is no combinational path from key.
- Pulses:
  - Exactly one cycle wide.
  - `pressed[i]` and `released[i]` are never both 1.
  - Channels are fully independent; simultaneous events on different channels each produce their own pulses in the same cycle.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Reset mid-count discards the partial count; a reset pulse during a held press drops held to 0 without a `released` pulse.

Optional Feature:
- Macro: KEY_DEBOUNCE_TOGGLE_EN.
- When defined:
  - Adds output `toggled[WIDTH]`, reset value 0.
  - `toggled[i]` inverts on every `pressed[i]` pulse, in the cycle after the pulse.
  - Intended for latched-LED labs.
- When undefined: the port and its flops are absent, and all other behaviour is identical.

Test Plan:
- Reset with key=2'b11, DEBOUNCE_CYCLES=4 → held=00, pressed=00, released=00 throughout and after release of reset.
- key[0] driven 1→0 and held → pressed[0]=1 for exactly one cycle 6±1 cycles after the edge; held[0]=1 from that cycle; channel 1 outputs unchanged.
- key[0] bounce pattern 0,1,0,1 with each level held 2 cycles, then 0 steady → no pulse during the bounce; a single pressed[0] 6±1 cycles after the final transition.
- Both keys released after being held (0→1 on the same cycle) → released=2'b11 in the same cycle, held=00.
- Key held low, reset pulsed low for 3 cycles mid-hold → held drops to 0 asynchronously with no released pulse; after reset deasserts, pressed pulses again after 6±1 cycles.
- With KEY_DEBOUNCE_TOGGLE_EN: three press/release cycles on key[1] → toggled[1] sequence 1,0,1; toggled[0] stays 0.
